// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS frame controller: FSM encoding and the
// seed substitution used to keep the XNOR LFSR out of its lock-up state.
`timescale 1ns/1ps
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_GAP
  } state_t;

  localparam logic [15:0] LOCKUP_SEED = 16'hFFFF;
  localparam logic [15:0] SAFE_SEED   = 16'h0000;

  // An all-ones XNOR LFSR never leaves that state, so swap it for all-zeros.
  function automatic logic [15:0] sanitize_seed(input logic [15:0] s);
    return (s == LOCKUP_SEED) ? SAFE_SEED : s;
  endfunction

endpackage

// File: rtl/lfsr16_step.sv
// 16-bit Fibonacci XNOR LFSR (taps 16,15,13,4) with load and stall control.
`timescale 1ns/1ps
module lfsr16_step
  import prbs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic fb;

  assign fb = ~(state[15] ^ state[14] ^ state[12] ^ state[3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= 16'h0000;
    end else if (load) begin
      state <= sanitize_seed(seed);
    end else if (advance) begin
      state <= {state[14:0], fb};
    end
  end

endmodule

// File: rtl/prbs_frame_ctrl.sv
// PRBS frame generator: emits framed LFSR beats with ready/valid handshake,
// optional repetition separated by idle gaps, and abort/done signalling.
`timescale 1ns/1ps
module prbs_frame_ctrl
  import prbs_pkg::*;
#(
  parameter int LEN_W = 12,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      seed,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             repeat_en,
  input  logic             bit_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             sof,
  output logic             eof,
  output logic [15:0]      state_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frame_cnt
);

  state_t           state;
  logic [15:0]      seed_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             rep_q;
  logic             last_beat;
  logic             lfsr_load;
  logic             lfsr_advance;

  assign bit_valid    = (state == ST_RUN);
  assign busy         = (state != ST_IDLE);
  assign last_beat    = (beat_cnt == len_q - LEN_W'(1));
  assign sof          = bit_valid && (beat_cnt == '0);
  assign eof          = bit_valid && last_beat;
  assign bit_out      = state_out[15];

  // Abort wins over a simultaneous handshake so the LFSR keeps its state.
  assign lfsr_load    = (state == ST_SEED) && !abort;
  assign lfsr_advance = bit_valid && bit_ready && !abort;

  lfsr16_step u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_advance),
    .seed    (seed_q),
    .state   (state_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      seed_q    <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      rep_q     <= 1'b0;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        done  <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              seed_q    <= seed;
              len_q     <= frame_len;
              gap_q     <= gap_len;
              rep_q     <= repeat_en;
              frame_cnt <= '0;
              beat_cnt  <= '0;
              if (frame_len == '0) begin
                done <= 1'b1;
              end else begin
                state <= ST_SEED;
              end
            end
          end
          ST_SEED: begin
            state <= ST_RUN;
          end
          ST_RUN: begin
            if (bit_ready) begin
              if (last_beat) begin
                beat_cnt <= '0;
                if (frame_cnt != 8'hFF) begin
                  frame_cnt <= frame_cnt + 8'd1;
                end
                if (!rep_q) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
                end else if (gap_q != '0) begin
                  state   <= ST_GAP;
                  gap_cnt <= '0;
                end
              end else begin
                beat_cnt <= beat_cnt + LEN_W'(1);
              end
            end
          end
          ST_GAP: begin
            if (gap_cnt == gap_q - GAP_W'(1)) begin
              state <= ST_RUN;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_frame_ctrl.sv
// Self-checking bench for prbs_frame_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_prbs_frame_ctrl;

  localparam int LEN_W = 12;
  localparam int GAP_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [15:0]      seed;
  logic [LEN_W-1:0] frame_len;
  logic [GAP_W-1:0] gap_len;
  logic             repeat_en;
  logic             bit_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             sof;
  logic             eof;
  logic [15:0]      state_out;
  logic             busy;
  logic             done;
  logic [7:0]       frame_cnt;

  int comparisons = 0;
  int failures    = 0;
  bit checking    = 1'b0;

  logic [15:0] exp49 [4] = '{16'h0000, 16'h0001, 16'h0003, 16'h0007};
  bit          exp52 [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  prbs_frame_ctrl #(.LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .frame_len (frame_len),
    .gap_len   (gap_len),
    .repeat_en (repeat_en),
    .bit_ready (bit_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .sof       (sof),
    .eof       (eof),
    .state_out (state_out),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  // Behavioural model: a sequence is "busy", optionally waiting one cycle to
  // load its seed, otherwise either streaming beats or counting down a gap.
  bit          m_busy = 0, m_load_pending = 0, m_rep = 0, m_done = 0;
  int          m_gap_left = 0, m_beat = 0, m_len = 0, m_gap = 0, m_frames = 0;
  logic [15:0] m_seed = 16'h0000, m_lfsr = 16'h0000;

  function automatic logic [15:0] prbsNext(input logic [15:0] s);
    return {s[14:0], ~(^(s & 16'hD008))};
  endfunction

  function automatic bit modelValid();
    return m_busy && !m_load_pending && (m_gap_left == 0);
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_busy = 0; m_load_pending = 0; m_gap_left = 0; m_beat = 0;
      m_lfsr = 16'h0000; m_frames = 0; m_len = 0;
    end else if (!m_busy) begin
      if (start && !abort) begin
        m_seed = seed; m_len = int'(frame_len); m_gap = int'(gap_len);
        m_rep = repeat_en; m_frames = 0; m_beat = 0;
        if (m_len == 0) m_done = 1'b1;
        else begin m_busy = 1; m_load_pending = 1; end
      end
    end else if (abort) begin
      m_busy = 0; m_load_pending = 0; m_gap_left = 0; m_done = 1'b1;
    end else if (m_load_pending) begin
      m_lfsr = (m_seed == 16'hFFFF) ? 16'h0000 : m_seed;
      m_load_pending = 0;
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else if (bit_ready) begin
      m_lfsr = prbsNext(m_lfsr);
      if (m_beat == m_len - 1) begin
        m_beat = 0;
        if (m_frames < 255) m_frames++;
        if (!m_rep) begin m_busy = 0; m_done = 1'b1; end
        else m_gap_left = m_gap;
      end else begin
        m_beat++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    comparisons++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("m_bit_valid", 16'(bit_valid), 16'(modelValid()));
      checkOutput("m_bit_out", 16'(bit_out), 16'(m_lfsr[15]));
      checkOutput("m_sof", 16'(sof), 16'(modelValid() && m_beat == 0));
      checkOutput("m_eof", 16'(eof), 16'(modelValid() && m_beat == m_len - 1));
      checkOutput("m_state_out", state_out, m_lfsr);
      checkOutput("m_busy", 16'(busy), 16'(m_busy));
      checkOutput("m_done", 16'(done), 16'(m_done));
      checkOutput("m_frame_cnt", 16'(frame_cnt), 16'(m_frames));
    end
  end

  task automatic applyStimulus(input logic [15:0] s, input int len, input int gap,
                               input bit rep);
    seed = s; frame_len = LEN_W'(len); gap_len = GAP_W'(gap); repeat_en = rep;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int xfers;
    bit seen;
    rst = 1; start = 0; abort = 0; seed = 0; frame_len = 0; gap_len = 0;
    repeat_en = 0; bit_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    checkOutput("rst_state_out", state_out, 16'h0000);
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_valid", 16'(bit_valid), 16'h0);
    checkOutput("rst_done", 16'(done), 16'h0);
    checkOutput("rst_frame_cnt", 16'(frame_cnt), 16'h0);
    @(posedge clk); #1;
    rst = 0;

    // Single frame of four beats from seed zero.
    bit_ready = 1;
    applyStimulus(16'h0000, 4, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("r049_state", state_out, exp49[i]);
      checkOutput("r049_bit", 16'(bit_out), 16'h0);
      checkOutput("r049_sof", 16'(sof), 16'(i == 0));
      checkOutput("r049_eof", 16'(eof), 16'(i == 3));
    end
    @(negedge clk);
    checkOutput("r049_done", 16'(done), 16'h1);
    checkOutput("r049_frame_cnt", 16'(frame_cnt), 16'h1);
    checkOutput("r049_valid_off", 16'(bit_valid), 16'h0);

    // Toggling ready: still exactly four transfers.
    applyStimulus(16'h0000, 4, 0, 0);
    xfers = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      bit_ready = ~bit_ready;
      @(negedge clk);
      if (bit_valid && bit_ready) xfers++;
      if (done) seen = 1;
    end
    checkOutput("r050_done_seen", 16'(seen), 16'h1);
    checkOutput("r050_xfers", 16'(xfers), 16'd4);

    // Lock-up seed substitution.
    @(posedge clk); #1;
    bit_ready = 1;
    applyStimulus(16'hFFFF, 2, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("r051_state0", state_out, 16'h0000);
    @(negedge clk);
    checkOutput("r051_state1", state_out, 16'h0001);
    @(negedge clk);

    // Repeated frames with a two-cycle gap, then abort.
    applyStimulus(16'h0000, 3, 2, 1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("r052_valid", 16'(bit_valid), 16'(exp52[i]));
      if (i == 5) checkOutput("r052_frame2_state", state_out, 16'h0007);
    end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_cnt == 8'd3) seen = 1;
    end
    checkOutput("r052_three_frames", 16'(seen), 16'h1);
    @(posedge clk); #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    @(negedge clk);
    checkOutput("r052_abort_done", 16'(done), 16'h1);
    checkOutput("r052_abort_busy", 16'(busy), 16'h0);
    checkOutput("r052_abort_cnt", 16'(frame_cnt), 16'd3);
    @(negedge clk);
    checkOutput("r052_done_once", 16'(done), 16'h0);

    // Zero-length frame, then a start while busy.
    applyStimulus(16'h1234, 0, 0, 0);
    @(negedge clk);
    checkOutput("r053_zero_done", 16'(done), 16'h1);
    checkOutput("r053_zero_busy", 16'(busy), 16'h0);
    checkOutput("r053_zero_valid", 16'(bit_valid), 16'h0);
    bit_ready = 0;
    applyStimulus(16'h0000, 5, 0, 0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(16'h0000, 2, 0, 0);
    bit_ready = 1;
    xfers = 0; seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bit_valid && bit_ready) xfers++;
      if (done) seen = 1;
    end
    checkOutput("r053_busy_start_xfers", 16'(xfers), 16'd5);

    // Abort beats start in IDLE.
    @(posedge clk); #1;
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    @(negedge clk);
    checkOutput("abort_start_busy", 16'(busy), 16'h0);
    checkOutput("abort_start_done", 16'(done), 16'h0);

    // Reset in the middle of a frame.
    applyStimulus(16'h00A5, 8, 0, 0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checkOutput("r054_state_out", state_out, 16'h0000);
    checkOutput("r054_valid", 16'(bit_valid), 16'h0);
    checkOutput("r054_busy", 16'(busy), 16'h0);
    checkOutput("r054_done", 16'(done), 16'h0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checkOutput("r054_no_done", 16'(done), 16'h0);

    // One-beat frames back-to-back until frame_cnt saturates.
    applyStimulus(16'h0000, 1, 0, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("len1_sof", 16'(sof), 16'h1);
    checkOutput("len1_eof", 16'(eof), 16'h1);
    repeat (270) @(negedge clk);
    checkOutput("sat_frame_cnt", 16'(frame_cnt), 16'd255);
    @(posedge clk); #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    @(negedge clk);
    checkOutput("sat_abort_done", 16'(done), 16'h1);
    checkOutput("sat_abort_cnt", 16'(frame_cnt), 16'd255);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bit_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 79) == 0);
      rst       = ($urandom_range(0, 599) == 0);
      seed      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      frame_len = LEN_W'($urandom_range(0, 6));
      gap_len   = GAP_W'($urandom_range(0, 3));
      repeat_en = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    start = 0; abort = 0; rst = 0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", comparisons, failures);
    $finish;
  end

endmodule
